// File: rtl/debounce_pkg.sv
// Shared types and defaults for the push-button debounce path.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000;
  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned REPEAT_DELAY_DEF    = 3000;
  localparam int unsigned REPEAT_PERIOD_DEF   = 1000;

  // Bits needed to hold 0..max_count inclusive, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous input bit.
module bit_synchronizer
  import debounce_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[STAGES-2:0], d};
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/button_debounce_pulse.sv
// Debounces a raw push-button and emits one pulse per accepted press.
// Define BUTTON_DEBOUNCE_REPEAT_EN to add auto-repeat pulses while held.
module button_debounce_pulse
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
  , parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF
  , parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic button_in,
  output logic button_pulse,
  output logic button_level
);

  localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_btn_s;
  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_pulse, w_pulse_nxt;
  logic             r_level, w_level_nxt;
  logic             w_rpt_fire;

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (button_in),
    .q     (w_btn_s)
  );

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
  localparam int unsigned RPT_W = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

  logic [RPT_W-1:0] r_rpt_cnt;
  logic             r_rpt_first;
  logic [RPT_W-1:0] w_rpt_last;

  assign w_rpt_last = r_rpt_first ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_PERIOD - 1);
  assign w_rpt_fire = (r_state == PRESSED) && (r_rpt_cnt == w_rpt_last);

  // Repeat timer only advances while PRESSED is held; any exit restarts the initial delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rpt_cnt   <= '0;
      r_rpt_first <= 1'b1;
    end else if ((r_state == PRESSED) && (w_state_nxt == PRESSED)) begin
      if (w_rpt_fire) begin
        r_rpt_cnt   <= '0;
        r_rpt_first <= 1'b0;
      end else begin
        r_rpt_cnt   <= r_rpt_cnt + 1'b1;
      end
    end else begin
      r_rpt_cnt   <= '0;
      r_rpt_first <= 1'b1;
    end
  end
`else
  assign w_rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_level <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= w_pulse_nxt;
      r_level <= w_level_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pulse_nxt = 1'b0;
    w_level_nxt = r_level;
    case (r_state)
      IDLE: begin
        w_level_nxt = 1'b0;
        w_cnt_nxt   = '0;
        if (w_btn_s) begin
          w_state_nxt = PRESS_CHK;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      PRESS_CHK: begin
        w_level_nxt = 1'b0;
        if (!w_btn_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
          w_pulse_nxt = 1'b1;
          w_level_nxt = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      PRESSED: begin
        w_level_nxt = 1'b1;
        w_cnt_nxt   = '0;
        if (!w_btn_s) begin
          w_state_nxt = RELEASE_CHK;
          w_cnt_nxt   = CNT_W'(1);
        end else if (w_rpt_fire) begin
          w_pulse_nxt = 1'b1;
        end
      end
      RELEASE_CHK: begin
        w_level_nxt = 1'b1;
        if (w_btn_s) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_level_nxt = 1'b0;
      end
    endcase
  end

  assign button_pulse = r_pulse;
  assign button_level = r_level;

endmodule
